// File: rtl/led_event_blinker.sv
// Turns single-cycle event strobes into visible LED blinks, one blink per event.
// Events arriving mid-blink are queued in a saturating counter and replayed in order.
module led_event_blinker #(
  parameter int ON_CYCLES   = 6250000,
  parameter int OFF_CYCLES  = 6250000,
  parameter int MAX_PENDING = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Event,
  output logic       o_LED,
  output logic       o_Busy,
  output logic [3:0] o_Pending,
  output logic       o_Drop
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  localparam logic [31:0] ON_LAST  = 32'(ON_CYCLES - 1);
  localparam logic [31:0] OFF_LAST = 32'(OFF_CYCLES - 1);
  localparam logic [3:0]  MAX_P    = 4'(MAX_PENDING);

  state_t      r_State;
  logic [31:0] r_Count;
  logic [3:0]  r_Pending;
  logic        r_Drop;
  logic        w_Deq;

  // A blink starts either from idle or straight out of the OFF gap.
  always_comb begin
    w_Deq = 1'b0;
    if (r_Pending != 4'd0) begin
      if (r_State == IDLE)
        w_Deq = 1'b1;
      else if ((r_State == OFF) && (r_Count == OFF_LAST))
        w_Deq = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State   <= IDLE;
      r_Count   <= 32'd0;
      r_Pending <= 4'd0;
      r_Drop    <= 1'b0;
    end else begin
      r_Drop <= 1'b0;
      // Simultaneous enqueue and dequeue cancel out and never count as a drop.
      if (i_Event && !w_Deq) begin
        if (r_Pending < MAX_P)
          r_Pending <= r_Pending + 4'd1;
        else
          r_Drop <= 1'b1;
      end else if (!i_Event && w_Deq) begin
        r_Pending <= r_Pending - 4'd1;
      end

      case (r_State)
        IDLE: begin
          if (r_Pending != 4'd0) begin
            r_State <= ON;
            r_Count <= 32'd0;
          end
        end
        ON: begin
          if (r_Count == ON_LAST) begin
            r_State <= OFF;
            r_Count <= 32'd0;
          end else begin
            r_Count <= r_Count + 32'd1;
          end
        end
        OFF: begin
          if (r_Count == OFF_LAST) begin
            r_Count <= 32'd0;
            r_State <= (r_Pending != 4'd0) ? ON : IDLE;
          end else begin
            r_Count <= r_Count + 32'd1;
          end
        end
        default: begin
          r_State <= IDLE;
          r_Count <= 32'd0;
        end
      endcase
    end
  end

  assign o_LED     = (r_State == ON);
  assign o_Busy    = (r_State != IDLE) || (r_Pending != 4'd0);
  assign o_Pending = r_Pending;
  assign o_Drop    = r_Drop;

endmodule
